// File: rtl/rgb_cmd_sender.sv
// rgb_cmd_sender: drives a remote RGB LED pattern by emitting the minimal
// set of 'R'/'G'/'B' toggle bytes, tracking the far-end state locally.
module rgb_cmd_sender #(
    parameter int GAP = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] target_i,
    input  logic       apply_i,
    input  logic       resync_i,
    input  logic       tx_ready_i,
    output logic [7:0] cmd_o,
    output logic       new_cmd_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [2:0] tracked_o
);

    localparam int CW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT_RDY,
        S_SEND,
        S_GAPWAIT
    } state_t;

    state_t        state_q;
    logic [2:0]    goal_q;
    logic [2:0]    tracked_q;
    logic [2:0]    sel_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    cmd_q;
    logic          new_cmd_q;
    logic          busy_q;
    logic          done_q;

    logic [2:0]    diff_d;
    logic [2:0]    pick_d;
    logic [2:0]    tracked_d;
    logic [7:0]    cmd_d;

    assign diff_d    = goal_q ^ tracked_q;
    assign tracked_d = tracked_q ^ sel_q;

    always_comb begin
        pick_d = 3'b000;
        if (diff_d[2]) begin
            pick_d = 3'b100;
        end else if (diff_d[1]) begin
            pick_d = 3'b010;
        end else if (diff_d[0]) begin
            pick_d = 3'b001;
        end
    end

    always_comb begin
        cmd_d = 8'd66;
        if (sel_q[2]) begin
            cmd_d = 8'd82;
        end else if (sel_q[1]) begin
            cmd_d = 8'd71;
        end
    end

    // done_q is precomputed on every entry to CHECK so it is visible
    // during the CHECK cycle that finds nothing left to toggle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            goal_q    <= 3'b111;
            tracked_q <= 3'b111;
            sel_q     <= 3'b000;
            cnt_q     <= '0;
            cmd_q     <= 8'h00;
            new_cmd_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            new_cmd_q <= 1'b0;
            done_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (apply_i) begin
                        goal_q  <= target_i;
                        busy_q  <= 1'b1;
                        done_q  <= (target_i == tracked_q);
                        state_q <= S_CHECK;
                    end else if (resync_i) begin
                        tracked_q <= 3'b111;
                    end
                end
                S_CHECK: begin
                    if (diff_d == 3'b000) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        sel_q   <= pick_d;
                        state_q <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (tx_ready_i) begin
                        new_cmd_q <= 1'b1;
                        cmd_q     <= cmd_d;
                        state_q   <= S_SEND;
                    end
                end
                S_SEND: begin
                    tracked_q <= tracked_d;
                    if (GAP == 0) begin
                        done_q  <= (goal_q == tracked_d);
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q   <= CW'(GAP - 1);
                        state_q <= S_GAPWAIT;
                    end
                end
                S_GAPWAIT: begin
                    if (cnt_q == '0) begin
                        done_q  <= (goal_q == tracked_q);
                        state_q <= S_CHECK;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_o     = cmd_q;
    assign new_cmd_o = new_cmd_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign tracked_o = tracked_q;

endmodule

// File: tb/tb_rgb_cmd_sender.sv
// Self-checking bench for rgb_cmd_sender: directed scenarios plus random
// targets compared against a command-list/timing reference model.
module tb_rgb_cmd_sender;

    localparam int GAP = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] target;
    logic       apply;
    logic       resync;
    logic       tx_ready;
    logic [7:0] cmd;
    logic       new_cmd;
    logic       busy;
    logic       done;
    logic [2:0] tracked;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int         nc_cyc[$];
    logic [7:0] nc_cmd[$];
    int         dn_cyc[$];

    logic [2:0] mtrk;

    rgb_cmd_sender #(.GAP(GAP)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .target_i   (target),
        .apply_i    (apply),
        .resync_i   (resync),
        .tx_ready_i (tx_ready),
        .cmd_o      (cmd),
        .new_cmd_o  (new_cmd),
        .busy_o     (busy),
        .done_o     (done),
        .tracked_o  (tracked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (new_cmd) begin
            nc_cyc.push_back(cyc);
            nc_cmd.push_back(cmd);
        end
        if (done) dn_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] letter(input int b);
        case (b)
            2: letter = 8'd82;
            1: letter = 8'd71;
            default: letter = 8'd66;
        endcase
    endfunction

    task automatic clear_mon();
        nc_cyc.delete();
        nc_cmd.delete();
        dn_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tracked"}, 32'(tracked), 32'h7);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_newcmd"}, 32'(new_cmd), 32'h0);
        chk({tag, "_cmd"}, 32'(cmd), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    task automatic do_resync();
        @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        chk("resync_tracked", 32'(tracked), 32'h7);
        mtrk = 3'b111;
    endtask

    // Apply tgt; stall = cycles TxReady is held low (0 or >=2).
    task automatic apply_check(input logic [2:0] tgt, input int stall,
                               input bit extra, input bit rsy);
        logic [7:0] exp_cmd[$];
        int ka;
        int ks;
        int first;
        int t;
        for (int b = 2; b >= 0; b--)
            if (tgt[b] != mtrk[b]) exp_cmd.push_back(letter(b));
        @(negedge clk);
        clear_mon();
        target   = tgt;
        apply    = 1'b1;
        resync   = rsy;
        tx_ready = (stall == 0);
        @(negedge clk);
        ka = cyc;
        chk("busy_rise", 32'(busy), 32'h1);
        resync = 1'b0;
        if (extra) target = ~tgt;
        apply = extra;
        if (stall == 0) begin
            @(negedge clk);
            apply = 1'b0;
            ks = ka + 2;
        end else begin
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                apply = 1'b0;
            end
            tx_ready = 1'b1;
            ks = cyc + 1;
        end
        first = (stall == 0) ? ka + 2 : ks;
        t = 0;
        while (dn_cyc.size() == 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (GAP + 10) @(negedge clk);
        chk("n_cmds", 32'(nc_cmd.size()), 32'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size() && i < nc_cmd.size(); i++) begin
            chk("cmd_byte", 32'(nc_cmd[i]), 32'(exp_cmd[i]));
            chk("cmd_cycle", 32'(nc_cyc[i]), 32'(first + i * (GAP + 3)));
        end
        chk("n_done", 32'(dn_cyc.size()), 32'h1);
        if (dn_cyc.size() > 0) begin
            if (exp_cmd.size() == 0)
                chk("done_cycle", 32'(dn_cyc[0]), 32'(ka));
            else
                chk("done_cycle", 32'(dn_cyc[0]),
                    32'(first + (exp_cmd.size() - 1) * (GAP + 3) + GAP + 1));
        end
        chk("tracked_final", 32'(tracked), 32'(tgt));
        chk("busy_final", 32'(busy), 32'h0);
        mtrk = tgt;
    endtask

    initial begin
        int t;
        rst_n    = 1'b0;
        target   = 3'b111;
        apply    = 1'b0;
        resync   = 1'b0;
        tx_ready = 1'b0;
        mtrk     = 3'b111;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst_n = 1'b1;
        clear_mon();
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("rst_rel");
        end
        chk("rst_no_done", 32'(dn_cyc.size()), 32'h0);

        apply_check(3'b011, 0, 1'b0, 1'b0);
        do_resync();
        apply_check(3'b000, 0, 1'b0, 1'b0);
        apply_check(3'b000, 0, 1'b1, 1'b0);
        do_resync();
        apply_check(3'b101, 20, 1'b0, 1'b0);
        apply_check(3'b010, 0, 1'b1, 1'b0);
        do_resync();

        // Reset during GAPWAIT between 'R' and 'G'.
        @(negedge clk);
        clear_mon();
        target   = 3'b000;
        apply    = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        apply = 1'b0;
        t = 0;
        while (nc_cyc.size() == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mid_first_cmd", 32'(nc_cmd.size() > 0 ? nc_cmd[0] : 8'h00),
            32'd82);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (30) @(negedge clk);
        chk("mid_no_cmd", 32'(nc_cyc.size()), 32'h0);
        chk("mid_no_done", 32'(dn_cyc.size()), 32'h0);
        chk("mid_tracked", 32'(tracked), 32'h7);
        mtrk = 3'b111;

        for (int n = 0; n < 12; n++) begin
            logic [2:0] tg;
            int st;
            if ($urandom_range(3) == 0) do_resync();
            tg = 3'($urandom_range(7));
            st = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(6, 2));
            apply_check(tg, st, 1'($urandom_range(1)),
                        1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_cmd_sender.md
# rgb_cmd_sender

Command-side counterpart of the RGB LED controller. Takes a desired active-low RGB pattern and emits the minimal sequence of toggle command bytes ('R' = 82, 'G' = 71, 'B' = 66) on a Cmd/NewCmd byte interface. That interface feeds the serial transmitter toward the board that owns the LEDs. A local mirror of the far-end LED state determines which toggles are needed.

## Interface
- GAP, 4: idle cycles enforced after each NewCmd pulse before the next command may be considered (0 allowed).
- Clock  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-low reset.
- Target  in  3  desired LED pattern, active-low; [2]=R, [1]=G, [0]=B (0 = lit).
- Apply  in  1  one-cycle request to drive the far end to Target; sampled only in IDLE.
- Resync  in  1  in IDLE, forces Tracked to 3'b111 (far end was reset); ignored otherwise.
- TxReady  in  1  downstream transmitter can accept a byte this cycle.
- Cmd  out  8  command byte; valid while NewCmd = 1, holds last value otherwise.
- NewCmd  out  1  one-cycle byte strobe.
- Busy  out  1  high from the cycle after an accepted Apply until the cycle Done pulses.
- Done  out  1  one-cycle pulse: Tracked equals latched goal.
- Tracked  out  3  mirror of far-end LED state, active-low.

## Operation
- Registers:
  - Goal[2:0], latched on accepted Apply.
  - Diff[2:0] = Goal ^ Tracked, recomputed in CHECK.
  - Gap counter, wide enough for GAP.
- States: IDLE, CHECK, WAIT_RDY, SEND, GAPWAIT.
- IDLE:
  - Apply=1: latch Goal=Target, go CHECK. Apply has priority over Resync in the same cycle; Resync is then ignored.
  - Else Resync=1: Tracked<=3'b111, stay IDLE.
- CHECK:
  - Diff==0: Done=1, Busy falls in the same cycle, go IDLE.
  - Else select the highest set Diff bit (R before G before B), go WAIT_RDY.
- WAIT_RDY: stay while TxReady=0; on TxReady=1 go SEND.
- SEND, one cycle:
  - NewCmd=1 with Cmd = 82, 71 or 66 for the selected bit.
  - Toggle that Tracked bit.
  - Go GAPWAIT, or go straight to CHECK when GAP=0.
- GAPWAIT: count GAP cycles, then go CHECK.
- Apply outside IDLE is dropped with no side effects; no queueing.
- At most 3 commands per Apply. Each bit is toggled at most once, so Tracked equals Goal at Done.
- Reset (Reset=0) at any cycle:
  - state IDLE, Tracked=3'b111, Goal=3'b111, Cmd=8'h00, NewCmd=0, Busy=0, Done=0, gap counter 0.
  - A command in progress is abandoned; no partial NewCmd.

## Timing
- All outputs are registered.
- Apply sampled high at edge k: Busy=1 and state CHECK from cycle k+1; WAIT_RDY from k+2.
- TxReady sampled high at the edge ending a WAIT_RDY cycle: NewCmd=1 during the next cycle. Tracked updates at the end of that cycle.
- Minimum NewCmd-to-NewCmd spacing, TxReady held high: GAP + 3 cycles (SEND, GAP × GAPWAIT, CHECK, WAIT_RDY). With GAP=4, pulses are 7 cycles apart.
- Done follows the last NewCmd by GAP + 1 cycles.
- For Apply with no change needed, Done is at k+1.
- TxReady is not required to stay high after acceptance; NewCmd never asserts while in WAIT_RDY.

## Test plan
- Reset held low 3 cycles, then released -> Tracked=111, Busy=0, NewCmd=0, Cmd=00 throughout; no Done.
- Tracked=111, Apply with Target=011, TxReady=1, GAP=4 -> exactly one NewCmd with Cmd=82; Tracked=011; Done 5 cycles after that pulse; Busy low afterwards.
- Tracked=111, Target=000, TxReady=1 -> NewCmd pulses carrying 82, 71, 66 in that order, 7 cycles apart; final Tracked=000; one Done.
- Tracked=000, Target=000 -> Done one cycle after Apply, no NewCmd. Second Apply issued while Busy -> no extra commands and no second Done.
- Target=101 from 111 with TxReady=0 for 20 cycles, then 1 -> NewCmd stays 0 during the stall; a single Cmd=71 is sent the cycle after TxReady is sampled high.
- Reset=0 asserted in GAPWAIT between the 'R' and 'G' commands -> all outputs return to reset values next cycle; no further NewCmd.
- Resync in IDLE after Tracked=010 -> Tracked=111.
